// File: rtl/layer_compositor.sv
// Priority compositor: merges NUM_LAYERS layers over a background in a 2-stage pipeline with aligned syncs.
// Optional frame-synchronous layer blinking is built when LAYER_COMPOSITOR_BLINK_EN is defined.
module layer_compositor #(
    parameter int NUM_LAYERS        = 4,
    parameter int COLOR_W           = 8,
    parameter int BLINK_HALF_FRAMES = 8,
    parameter int IDX_W             = $clog2(NUM_LAYERS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          display_enable_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [COLOR_W-1:0]            background_color_in,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color_in,
    input  logic [NUM_LAYERS-1:0]         layer_visible_in,
    input  logic [NUM_LAYERS-1:0]         layer_enable_in,
    input  logic [NUM_LAYERS-1:0]         layer_blink_in,
    output logic [COLOR_W-1:0]            final_pixel_color_out,
    output logic                          display_enable_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          winner_valid_out,
    output logic [IDX_W-1:0]              winner_idx_out,
    output logic                          collision_out,
    output logic                          collision_frame_out
);

    localparam int CNT_W = $clog2(NUM_LAYERS + 1);

    logic                  vsync_prev;
    logic                  frame_tick;
    logic [NUM_LAYERS-1:0] blink_mask;
    logic [NUM_LAYERS-1:0] eff;

    // Stage 0: frame tick on the falling edge of the active-low vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_prev <= 1'b0;
        else        vsync_prev <= vsync_in;
    end

    assign frame_tick = vsync_prev & ~vsync_in;

`ifdef LAYER_COMPOSITOR_BLINK_EN
    typedef enum logic {BLINK_ON, BLINK_OFF} blink_state_t;

    blink_state_t blink_state;
    logic [7:0]   frame_cnt;
    logic         blink_off;

    // blink_off only moves on a tick, so a frame is never torn mid-image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_state <= BLINK_ON;
            frame_cnt   <= 8'd0;
            blink_off   <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == 8'(BLINK_HALF_FRAMES - 1)) begin
                frame_cnt <= 8'd0;
                case (blink_state)
                    BLINK_ON: begin
                        blink_state <= BLINK_OFF;
                        blink_off   <= 1'b1;
                    end
                    default: begin
                        blink_state <= BLINK_ON;
                        blink_off   <= 1'b0;
                    end
                endcase
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign blink_mask = layer_blink_in & {NUM_LAYERS{blink_off}};
`else
    logic unused_blink;
    assign unused_blink = ^layer_blink_in;
    assign blink_mask   = '0;
`endif

    assign eff = layer_visible_in & layer_enable_in & ~blink_mask;

    logic [IDX_W-1:0]   top_idx;
    logic [COLOR_W-1:0] top_color;
    logic [CNT_W-1:0]   pop;

    // Ascending scan: the last set layer seen is the highest index, i.e. the winner.
    always_comb begin
        top_idx   = '0;
        top_color = '0;
        pop       = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (eff[i]) begin
                top_idx   = IDX_W'(i);
                top_color = layer_color_in[i*COLOR_W +: COLOR_W];
                pop       = pop + CNT_W'(1);
            end
        end
    end

    logic [IDX_W-1:0]   s1_idx;
    logic [COLOR_W-1:0] s1_color;
    logic [COLOR_W-1:0] s1_bg;
    logic               s1_hit;
    logic               s1_multi;
    logic               s1_de;
    logic               s1_hs;
    logic               s1_vs;
    logic               s1_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_idx   <= '0;
            s1_color <= '0;
            s1_bg    <= '0;
            s1_hit   <= 1'b0;
            s1_multi <= 1'b0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_tick  <= 1'b0;
        end else begin
            s1_idx   <= top_idx;
            s1_color <= top_color;
            s1_bg    <= background_color_in;
            s1_hit   <= (pop != '0);
            s1_multi <= (pop >= CNT_W'(2));
            s1_de    <= display_enable_in;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_tick  <= frame_tick;
        end
    end

    logic coll_now;
    logic coll_acc;

    assign coll_now = s1_de & s1_multi;

    // A collision on the tick pixel itself belongs to the frame being closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            final_pixel_color_out <= '0;
            display_enable_out    <= 1'b0;
            hsync_out             <= 1'b0;
            vsync_out             <= 1'b0;
            winner_valid_out      <= 1'b0;
            winner_idx_out        <= '0;
            collision_out         <= 1'b0;
            collision_frame_out   <= 1'b0;
            coll_acc              <= 1'b0;
        end else begin
            display_enable_out <= s1_de;
            hsync_out          <= s1_hs;
            vsync_out          <= s1_vs;
            winner_valid_out   <= s1_de & s1_hit;
            winner_idx_out     <= (s1_de & s1_hit) ? s1_idx : '0;
            collision_out      <= coll_now;
            if (!s1_de)      final_pixel_color_out <= '0;
            else if (s1_hit) final_pixel_color_out <= s1_color;
            else             final_pixel_color_out <= s1_bg;
            if (s1_tick) begin
                collision_frame_out <= coll_acc | coll_now;
                coll_acc            <= 1'b0;
            end else begin
                coll_acc <= coll_acc | coll_now;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized bench for layer_compositor: a frame-level reference model predicts every output 2 clk later.
module tb_layer_compositor;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HALF = 2;
  localparam int IW   = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           de_in, hs_in, vs_in;
  logic [W-1:0]   bg_in;
  logic [N*W-1:0] col_in;
  logic [N-1:0]   vis_in, en_in, blk_in;
  logic [W-1:0]   color_out;
  logic           de_out, hs_out, vs_out, valid_out, coll_out, coll_frame_out;
  logic [IW-1:0]  idx_out;

  layer_compositor #(
    .NUM_LAYERS(N), .COLOR_W(W), .BLINK_HALF_FRAMES(HALF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .display_enable_in(de_in), .hsync_in(hs_in), .vsync_in(vs_in),
    .background_color_in(bg_in), .layer_color_in(col_in),
    .layer_visible_in(vis_in), .layer_enable_in(en_in), .layer_blink_in(blk_in),
    .final_pixel_color_out(color_out), .display_enable_out(de_out),
    .hsync_out(hs_out), .vsync_out(vs_out),
    .winner_valid_out(valid_out), .winner_idx_out(idx_out),
    .collision_out(coll_out), .collision_frame_out(coll_frame_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {color, de, hs, vs, valid, idx, coll, coll_frame}
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  // model state at frame level
  logic m_vs_prev;
  int   m_ticks;
  logic m_frame_coll;
  logic m_cf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_vs_prev    = 1'b0;
    m_ticks      = 0;
    m_frame_coll = 1'b0;
    m_cf         = 1'b0;
  endtask

  task automatic apply(input logic de, input logic hs, input logic vs, input logic [W-1:0] bg,
                       input logic [N*W-1:0] col, input logic [N-1:0] vis,
                       input logic [N-1:0] en, input logic [N-1:0] blk);
    logic        tick, boff, wv, coll;
    int          top, cnt;
    logic [W-1:0] c;
    de_in = de; hs_in = hs; vs_in = vs; bg_in = bg;
    col_in = col; vis_in = vis; en_in = en; blk_in = blk;
    tick = m_vs_prev && !vs;
    m_vs_prev = vs;
`ifdef LAYER_COMPOSITOR_BLINK_EN
    boff = ((m_ticks / HALF) % 2) == 1;
`else
    boff = 1'b0;
`endif
    top = -1;
    cnt = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vis[i] && en[i] && !(blk[i] && boff)) begin
        cnt++;
        if (top < 0) top = i;
      end
    end
    wv   = de && (cnt > 0);
    coll = de && (cnt > 1);
    if (!de)         c = '0;
    else if (cnt > 0) c = col[top*W +: W];
    else             c = bg;
    if (tick) begin
      m_cf = m_frame_coll | coll;
      m_frame_coll = 1'b0;
      m_ticks++;
    end else begin
      m_frame_coll = m_frame_coll | coll;
    end
    exp_q.push_back({c, de, hs, vs, wv, (wv ? IW'(top) : IW'(0)), coll, m_cf});
  endtask

  task automatic compare_out();
    logic [15:0] e;
    e = exp_q.pop_front();
    check("color", 32'(color_out), 32'(e[15:8]));
    check("de", 32'(de_out), 32'(e[7]));
    check("hsync", 32'(hs_out), 32'(e[6]));
    check("vsync", 32'(vs_out), 32'(e[5]));
    check("valid", 32'(valid_out), 32'(e[4]));
    check("idx", 32'(idx_out), 32'(e[3:2]));
    check("coll", 32'(coll_out), 32'(e[1]));
    check("coll_frame", 32'(coll_frame_out), 32'(e[0]));
  endtask

  // driver: one pixel per clock, outputs compared 2 clk after their inputs
  task automatic pixel(input logic de, input logic hs, input logic vs, input logic [W-1:0] bg,
                       input logic [N*W-1:0] col, input logic [N-1:0] vis,
                       input logic [N-1:0] en, input logic [N-1:0] blk);
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) compare_out();
    apply(de, hs, vs, bg, col, vis, en, blk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_color"}, 32'(color_out), 32'd0);
    check({tag, "_de"}, 32'(de_out), 32'd0);
    check({tag, "_hs"}, 32'(hs_out), 32'd0);
    check({tag, "_vs"}, 32'(vs_out), 32'd0);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_idx"}, 32'(idx_out), 32'd0);
    check({tag, "_coll"}, 32'(coll_out), 32'd0);
    check({tag, "_cframe"}, 32'(coll_frame_out), 32'd0);
  endtask

  // asynchronous reset between edges; outputs must clear without a clock edge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0);
  endtask

  // 8 active pixels with vsync high, then 2 blanked pixels with vsync low (one tick per frame)
  task automatic frame(input int mode);
    logic [N*W-1:0] col;
    logic [N-1:0]   vis, en, blk;
    logic [W-1:0]   bg;
    logic           de;
    for (int p = 0; p < 8; p++) begin
      col = 32'h44332211; en = '1; blk = '0; de = 1'b1;
      bg  = W'($urandom);
      case (mode)
        0: begin vis = 4'b0100; blk = 4'b0100; end
        1: begin
          col = $urandom; vis = N'($urandom); en = N'($urandom); blk = N'($urandom);
          de  = ($urandom_range(0, 3) != 0);
        end
        2: vis = N'(1 << $urandom_range(0, N - 1));
        default: vis = (p == 3) ? 4'b1001 : 4'b0010;
      endcase
      pixel(de, (p >= 6), 1'b1, bg, col, vis, en, blk);
    end
    for (int p = 0; p < 2; p++)
      pixel(1'b0, 1'($urandom), 1'b0, W'($urandom), $urandom, N'($urandom), N'($urandom), N'($urandom));
  endtask

  initial begin
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b1; bg_in = '0;
    col_in = '0; vis_in = '0; en_in = '0; blk_in = '0;
    model_reset();
    do_reset("rst");

    // priority, gating, blanking
    pixel(1'b1, 1'b1, 1'b1, 8'h55, 32'h44332211, 4'b1111, 4'b1111, 4'b0000);
    pixel(1'b1, 1'b0, 1'b1, 8'h55, 32'h44332211, 4'b0010, 4'b0000, 4'b0000);
    pixel(1'b1, 1'b1, 1'b1, 8'h55, 32'h44332211, 4'b0010, 4'b0010, 4'b0000);
    pixel(1'b0, 1'b1, 1'b1, 8'h55, 32'h44332211, 4'b1111, 4'b1111, 4'b0000);
    pixel(1'b1, 1'b0, 1'b1, 8'h55, 32'h44332211, 4'b1011, 4'b1110, 4'b0000);

    // collision frame flag: clean, overlap, clean, clean
    frame(2); frame(3); frame(2); frame(2); frame(3); frame(3); frame(2);

    // blinking layer 2, then mid-line reset while hidden
    repeat (8) frame(0);
`ifdef LAYER_COMPOSITOR_BLINK_EN
    while (((m_ticks / HALF) % 2) == 0) frame(0);
`endif
    repeat (3) pixel(1'b1, 1'b0, 1'b1, 8'h5a, 32'h44332211, 4'b0100, 4'b1111, 4'b0100);
    do_reset("midrst");
    repeat (6) frame(0);

    // random frames
    repeat (16) frame(1);

    repeat (3) pixel(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
